i2c_master_arbiter: RTL and testbench



---
 rtl/i2c_master_arbiter_pkg.sv | 26 ++
 rtl/i2c_master_arbiter_slot.sv | 29 ++
 rtl/i2c_master_arbiter.sv | 155 +++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_master_arbiter_pkg.sv
// Shared command bits, arbiter state encoding and slot payload type for the
// two-port I2C master arbiter.
package i2c_master_arbiter_pkg;

  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_WRITE = 4'b0010;
  localparam logic [3:0] CMD_READ  = 4'b0100;
  localparam logic [3:0] CMD_STOP  = 4'b1000;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_HOLD  = 4'b1000
  } arb_state_e;

  typedef struct packed {
    logic [3:0] cmd;
    logic [7:0] data;
  } arb_byte_t;

  function automatic logic has_stop(input logic [3:0] c);
    return (c & CMD_STOP) != 4'b0000;
  endfunction

endpackage

// File: rtl/i2c_master_arbiter_slot.sv
// Per-port capture register: holds one pending byte request until the
// arbiter issues it to the master.
module i2c_arb_slot
  import i2c_master_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      load,
  input  logic      clear,
  input  arb_byte_t in_byte,
  output logic      valid,
  output arb_byte_t slot_byte
);

  // NOTE: the payload is reset as well as the valid bit, so nothing undefined
  // can ever be muxed onto the master bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= 1'b0;
      slot_byte <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load && !valid) begin
      valid     <= 1'b1;
      slot_byte <= in_byte;
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Two-port arbiter in front of the shared I2C master; holds the grant from the
// first byte to the STOP byte. Optional HOLD watchdog under I2C_ARB_WDOG_EN.
module i2c_master_arbiter
  import i2c_master_arbiter_pkg::*;
#(
  parameter int WDOG_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [3:0] cmd0,
  input  logic [7:0] dout0,
  output logic       done0,
  output logic [7:0] din0,
  input  logic       req1,
  input  logic [3:0] cmd1,
  input  logic [7:0] dout1,
  output logic       done1,
  output logic [7:0] din1,
  output logic       req,
  output logic [3:0] cmd,
  output logic [7:0] dout,
  input  logic       done,
  input  logic [7:0] din,
  output logic       busy,
  output logic       owner,
  output logic       wdog_err
);

  arb_state_e state, next_state;
  arb_byte_t  in0, in1, slot0, slot1, grant_byte;
  logic       valid0, valid1;
  logic       rr, issued_stop;
  logic       winner, grant_port, owner_valid;
  logic       issue_next, release_lock, wdog_expire;

  assign in0 = '{cmd: cmd0, data: dout0};
  assign in1 = '{cmd: cmd1, data: dout1};

  i2c_arb_slot u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (req0),
    .clear     (state == ST_ISSUE && !owner),
    .in_byte   (in0),
    .valid     (valid0),
    .slot_byte (slot0)
  );

  i2c_arb_slot u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (req1),
    .clear     (state == ST_ISSUE && owner),
    .in_byte   (in1),
    .valid     (valid1),
    .slot_byte (slot1)
  );

  // In IDLE the byte comes from the new winner, otherwise from the lock owner.
  assign winner      = (valid0 && valid1) ? rr : valid1;
  assign grant_port  = (state == ST_IDLE) ? winner : owner;
  assign grant_byte  = grant_port ? slot1 : slot0;
  assign owner_valid = owner ? valid1 : valid0;
  assign issue_next  = (next_state == ST_ISSUE);

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    next_state   = state;
    release_lock = 1'b0;
    unique case (state)
      ST_IDLE:  if (valid0 || valid1) next_state = ST_ISSUE;
      ST_ISSUE: next_state = ST_WAIT;
      ST_WAIT: begin
        if (done) begin
          if (issued_stop) begin
            next_state   = ST_IDLE;
            release_lock = 1'b1;
          end else begin
            next_state = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (owner_valid) begin
          next_state = ST_ISSUE;
        end else if (wdog_expire) begin
          next_state   = ST_IDLE;
          release_lock = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register here samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      req         <= 1'b0;
      cmd         <= '0;
      dout        <= '0;
      owner       <= 1'b0;
      busy        <= 1'b0;
      rr          <= 1'b0;
      issued_stop <= 1'b0;
    end else begin
      state <= next_state;
      req   <= issue_next;
      cmd   <= issue_next ? grant_byte.cmd  : 4'h0;
      dout  <= issue_next ? grant_byte.data : 8'h00;
      if (issue_next) issued_stop <= has_stop(grant_byte.cmd);
      if (state == ST_IDLE && issue_next) begin
        owner <= winner;
        busy  <= 1'b1;
      end
      if (release_lock) begin
        busy <= 1'b0;
        rr   <= ~owner;
      end
    end
  end

  assign done0 = done && (state == ST_WAIT) && !owner;
  assign done1 = done && (state == ST_WAIT) && owner;
  assign din0  = owner ? 8'h00 : din;
  assign din1  = owner ? din : 8'h00;

`ifdef I2C_ARB_WDOG_EN
  localparam int CNT_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  logic [CNT_W-1:0] wdog_cnt;

  // A byte already waiting from the owner takes precedence over expiry.
  assign wdog_expire = (state == ST_HOLD) && !owner_valid &&
                       (wdog_cnt == CNT_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (state == ST_HOLD && next_state == ST_HOLD) wdog_cnt <= wdog_cnt + 1'b1;
      else                                           wdog_cnt <= '0;
      if (wdog_expire) wdog_err <= 1'b1;
    end
  end
`else
  assign wdog_expire = 1'b0;
  // Watchdog compiled out: the flag is constant low for any legal timeout.
  assign wdog_err    = (WDOG_CYCLES < 0);
`endif

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Scoreboard bench for i2c_master_arbiter: a master model pops expected bytes
// in grant order and checks command, data, owner, latency and done/din routing.
module tb_i2c_master_arbiter;
  import i2c_master_arbiter_pkg::*;

`ifdef I2C_ARB_WDOG_EN
  localparam int WD = 16;
`else
  localparam int WD = 1_000_000;
`endif

  localparam logic [3:0] SW  = CMD_START | CMD_WRITE;
  localparam logic [3:0] WR  = CMD_WRITE;
  localparam logic [3:0] PW  = CMD_STOP | CMD_WRITE;
  localparam logic [3:0] SPW = CMD_START | CMD_STOP | CMD_WRITE;
  localparam logic [3:0] PR  = CMD_STOP | CMD_READ;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [3:0] cmd0 = '0, cmd1 = '0;
  logic [7:0] dout0 = '0, dout1 = '0;
  logic done0, done1, req, busy, owner, wdog_err;
  logic [7:0] din0, din1, dout;
  logic [3:0] cmd;
  logic done;
  logic [7:0] din;

  i2c_master_arbiter #(.WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .cmd0(cmd0), .dout0(dout0), .done0(done0), .din0(din0),
    .req1(req1), .cmd1(cmd1), .dout1(dout1), .done1(done1), .din1(din1),
    .req(req), .cmd(cmd), .dout(dout), .done(done), .din(din),
    .busy(busy), .owner(owner), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         port;
    logic [3:0] c;
    logic [7:0] d;
    bit         gap;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0, n_fail = 0;
  int   n_done0 = 0, n_done1 = 0;
  int   t_drive = 0, done_cyc = 0, exp_port = 0, mst_cnt = 0;
  bit   lat_check = 1'b0, use_fixed = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && done0) n_done0 <= n_done0 + 1;
    if (rst_n && done1) n_done1 <= n_done1 + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic expect_byte(input int p, input logic [3:0] c, input logic [7:0] d, input bit gap);
    sb.push_back('{port: p, c: c, d: d, gap: gap});
  endtask

  // Master model: answers each req with done 10 cycles later.
  initial begin
    exp_t e;
    done = 1'b0;
    din  = 8'h00;
    forever begin
      @(posedge clk); #1;
      done = 1'b0;
      if (mst_cnt > 0) begin
        mst_cnt--;
        if (mst_cnt == 0) begin
          done     = 1'b1;
          din      = use_fixed ? 8'h5C : 8'($urandom);
          done_cyc = cyc;
        end
      end
      @(negedge clk);
      if (!rst_n) begin
        mst_cnt = 0;
      end else begin
        if (req) begin
          if (sb.size() == 0) begin
            check("unexpected_req", {cmd, dout}, 32'h0);
          end else begin
            e = sb.pop_front();
            exp_port = e.port;
            check("m_cmd", cmd, e.c);
            check("m_dout", dout, e.d);
            check("m_owner", owner, e.port);
            if (e.gap) check("gap_after_stop", cyc - done_cyc, 2);
            if (lat_check) check("req_latency", cyc - t_drive, 2);
          end
          mst_cnt = 10;
        end
        if (done) begin
          check("done0_route", done0, exp_port == 0);
          check("done1_route", done1, exp_port == 1);
          check("din0_route", din0, (exp_port == 0) ? din : 8'h00);
          check("din1_route", din1, (exp_port == 1) ? din : 8'h00);
        end
      end
    end
  end

  task automatic pulse(input int p, input logic [3:0] c, input logic [7:0] d);
    @(posedge clk); #1;
    t_drive = cyc;
    if (p == 0) begin req0 = 1'b1; cmd0 = c; dout0 = d; end
    else        begin req1 = 1'b1; cmd1 = c; dout1 = d; end
    @(posedge clk); #1;
    if (p == 0) begin req0 = 1'b0; cmd0 = '0; dout0 = '0; end
    else        begin req1 = 1'b0; cmd1 = '0; dout1 = '0; end
  endtask

  task automatic wait_done(input int p, input bit stop);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = (p == 0) ? done0 : done1;
    end
    check($sformatf("done%0d_seen", p), seen, 1);
    if (seen) begin
      check("busy_at_done", busy, 1);
      if (stop) begin
        @(posedge clk); #1;
        check("busy_after_stop", busy, 0);
      end
    end
  endtask

  task automatic send(input int p, input logic [3:0] c, input logic [7:0] d);
    pulse(p, c, d);
    wait_done(p, has_stop(c));
  endtask

  initial begin
    int b0, b1;
`ifdef I2C_ARB_WDOG_EN
    int c0;
    bit seen;
`endif
    repeat (3) @(negedge clk);
    check("rst_req", req, 0);
    check("rst_cmd", cmd, 0);
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_wdog", wdog_err, 0);
    check("rst_done", {done0, done1}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_req", req, 0);

    // Single port-0 write with latency checks on first byte and HOLD bytes.
    b0 = n_done0; b1 = n_done1;
    expect_byte(0, SW, 8'h78, 0);
    expect_byte(0, WR, 8'h30, 0);
    expect_byte(0, PW, 8'h08, 0);
    lat_check = 1'b1;
    send(0, SW, 8'h78);
    send(0, WR, 8'h30);
    send(0, PW, 8'h08);
    lat_check = 1'b0;
    check("t1_done0_count", n_done0 - b0, 3);
    check("t1_done1_count", n_done1 - b1, 0);

    // Reset in the middle of a port-1 transaction.
    expect_byte(1, SW, 8'h12, 0);
    pulse(1, SW, 8'h12);
    repeat (3) @(negedge clk);
    check("mid_busy", busy, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_owner", owner, 0);
    check("mid_rst_cmd", cmd, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Simultaneous requests from reset: port 0 first, whole transaction.
    expect_byte(0, SW, 8'hA0, 0);
    expect_byte(0, WR, 8'hA1, 0);
    expect_byte(0, PW, 8'hA2, 0);
    expect_byte(1, SW, 8'hB0, 0);
    expect_byte(1, WR, 8'hB1, 0);
    expect_byte(1, PW, 8'hB2, 0);
    fork
      begin send(0, SW, 8'hA0); send(0, WR, 8'hA1); send(0, PW, 8'hA2); end
      begin send(1, SW, 8'hB0); send(1, WR, 8'hB1); send(1, PW, 8'hB2); end
    join

    // After a lone port-0 lock the next simultaneous pair goes to port 1.
    expect_byte(0, SPW, 8'hC0, 0);
    send(0, SPW, 8'hC0);
    expect_byte(1, SPW, 8'hD1, 0);
    expect_byte(0, SPW, 8'hD0, 0);
    fork
      send(0, SPW, 8'hD0);
      send(1, SPW, 8'hD1);
    join

    // Port 1 arrives while port 0 is in HOLD: starts two cycles after STOP done.
    expect_byte(0, SW, 8'h40, 0);
    expect_byte(0, WR, 8'h41, 0);
    expect_byte(0, PW, 8'h42, 0);
    expect_byte(1, SW, 8'h72, 1);
    expect_byte(1, PW, 8'h73, 0);
    send(0, SW, 8'h40);
    pulse(1, SW, 8'h72);
    send(0, WR, 8'h41);
    send(0, PW, 8'h42);
    wait_done(1, 0);
    send(1, PW, 8'h73);

    // Duplicate port-0 request while its slot waits behind a port-1 lock.
    expect_byte(1, SW, 8'h90, 0);
    expect_byte(1, PW, 8'h91, 0);
    expect_byte(0, SPW, 8'h55, 0);
    send(1, SW, 8'h90);
    pulse(0, SPW, 8'h55);
    pulse(0, SPW, 8'hAA);
    send(1, PW, 8'h91);
    wait_done(0, 1);

    // Port-0 read byte with a fixed master read value.
    use_fixed = 1'b1;
    expect_byte(0, PR, 8'h00, 0);
    send(0, PR, 8'h00);
    use_fixed = 1'b0;

`ifdef I2C_ARB_WDOG_EN
    // Owner stalls in HOLD; watchdog drops the lock and port 1 goes next.
    expect_byte(0, SW, 8'h21, 0);
    expect_byte(1, SPW, 8'h31, 0);
    send(0, SW, 8'h21);
    c0 = cyc;
    pulse(1, SPW, 8'h31);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = wdog_err;
    end
    check("wdog_seen", seen, 1);
    check("wdog_latency", cyc - c0, 17);
    check("wdog_busy", busy, 0);
    wait_done(1, 1);
    check("wdog_sticky", wdog_err, 1);
`else
    check("wdog_off", wdog_err, 0);
`endif

    repeat (15) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("final_idle_busy", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
